// File: rtl/apb_transfer_ctrl_pkg.sv
// apb_transfer_ctrl_pkg: shared types, response/burst codes and sizing for the AXI-APB burst sequencer
`ifndef SLAVE_CNT
`define SLAVE_CNT 4
`endif
package apb_transfer_ctrl_pkg;
  localparam int SLAVE_CNT = `SLAVE_CNT;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, RRESP, BRESP, ERR} state_e;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction
endpackage

// File: rtl/apb_transfer_ctrl_addr_gen.sv
// apb_addr_gen: next beat address for FIXED/INCR/WRAP bursts of 4-byte beats
module apb_addr_gen
  import apb_transfer_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);
  logic [ADDR_W-1:0] mask, incr;
  assign mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << 2) - ADDR_W'(1);
  assign incr = addr_i + ADDR_W'(4);
  assign next_addr_o = burst_i == BURST_INCR ? incr :
                       burst_i == BURST_WRAP ? (addr_i & ~mask) | (incr & mask) : addr_i;
endmodule

// File: rtl/apb_transfer_ctrl.sv
// apb_transfer_ctrl: runs one APB SETUP/ACCESS transfer per AXI beat, or drains error bursts without APB traffic
module apb_transfer_ctrl
  import apb_transfer_ctrl_pkg::*;
(
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [ADDR_W-1:0]    cmd_addr_i,
  input  logic [7:0]           cmd_len_i,
  input  logic [1:0]           cmd_burst_i,
  input  logic                 cmd_write_i,
  input  logic [SLAVE_CNT-1:0] true_psel_i,
  input  logic                 dec_error_i,
  input  logic                 nonexist_transfer_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [3:0]           wstrb_i,
  output logic [SLAVE_CNT-1:0] psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [ADDR_W-1:0]    paddr_o,
  output logic [DATA_W-1:0]    pwdata_o,
  output logic [3:0]           pstrb_o,
  input  logic [DATA_W-1:0]    prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_W-1:0]    rsp_data_o,
  output logic [1:0]           rsp_resp_o,
  output logic                 rsp_last_o
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, next_addr;
  logic [7:0] len_q, beat_q;
  logic [1:0] burst_q, resp_q;
  logic write_q;
  logic [SLAVE_CNT-1:0] psel_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;
  logic cmd_err, last, active, err_step;
  assign cmd_err = dec_error_i | nonexist_transfer_i | ~|true_psel_i |
                   (cmd_burst_i == BURST_WRAP && !wrap_len_ok(cmd_len_i));
  assign last = beat_q == len_q;
  assign err_step = write_q ? wdata_valid_i : rsp_ready_i;
  apb_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = cmd_err ? ERR : cmd_write_i ? WDATA : SETUP;
      WDATA:   if (wdata_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i) state_d = !write_q ? RRESP : last ? BRESP : WDATA;
      RRESP:   if (rsp_ready_i) state_d = last ? IDLE : SETUP;
      BRESP:   if (rsp_ready_i) state_d = IDLE;
      ERR:     if (err_step && last) state_d = write_q ? BRESP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // resp_q carries the error code for drained bursts and the sticky write error otherwise
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      write_q <= 1'b0;
      psel_q  <= '0;
      resp_q  <= RESP_OKAY;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          addr_q  <= cmd_addr_i;
          len_q   <= cmd_len_i;
          burst_q <= cmd_burst_i;
          write_q <= cmd_write_i;
          psel_q  <= true_psel_i;
          beat_q  <= '0;
          resp_q  <= !cmd_err ? RESP_OKAY : dec_error_i ? RESP_DECERR : RESP_SLVERR;
        end
        WDATA: if (wdata_valid_i) begin
          wdata_q <= wdata_i;
          wstrb_q <= wstrb_i;
        end
        ACCESS: if (pready_i) begin
          if (!write_q) begin
            rdata_q <= prdata_i;
            resp_q  <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
          end else begin
            if (pslverr_i) resp_q <= RESP_SLVERR;
            if (!last) begin
              addr_q <= next_addr;
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        RRESP: if (rsp_ready_i && !last) begin
          addr_q <= next_addr;
          beat_q <= beat_q + 8'd1;
        end
        ERR: if (err_step && !last) beat_q <= beat_q + 8'd1;
        default: ;
      endcase
    end
  end
  always_comb begin
    active        = state_q == SETUP || state_q == ACCESS;
    cmd_ready_o   = aresetn && state_q == IDLE;
    wdata_ready_o = state_q == WDATA || (state_q == ERR && write_q);
    psel_o        = active ? psel_q : '0;
    penable_o     = state_q == ACCESS;
    pwrite_o      = active && write_q;
    paddr_o       = active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    pwdata_o      = active && write_q ? wdata_q : '0;
    pstrb_o       = active && write_q ? wstrb_q : '0;
    rsp_valid_o   = state_q inside {RRESP, BRESP} || (state_q == ERR && !write_q);
    rsp_data_o    = state_q == RRESP ? rdata_q : '0;
    rsp_resp_o    = rsp_valid_o ? resp_q : RESP_OKAY;
    rsp_last_o    = state_q == BRESP || (rsp_valid_o && last);
  end
endmodule

// File: tb/tb_apb_transfer_ctrl.sv
// tb_apb_transfer_ctrl: randomized APB slave / AXI master bench with a burst-level reference model
module tb_apb_transfer_ctrl;
  import apb_transfer_ctrl_pkg::*;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic cmd_valid_i, cmd_ready_o, cmd_write_i, dec_error_i, nonexist_transfer_i;
  logic [31:0] cmd_addr_i, wdata_i, pwdata_o, paddr_o, prdata_i, rsp_data_o;
  logic [7:0] cmd_len_i;
  logic [1:0] cmd_burst_i, rsp_resp_o;
  logic [SLAVE_CNT-1:0] true_psel_i, psel_o;
  logic wdata_valid_i, wdata_ready_o, penable_o, pwrite_o, pready_i, pslverr_i;
  logic rsp_valid_o, rsp_ready_i, rsp_last_o;
  logic [3:0] wstrb_i, pstrb_o;
  int total = 0, bad = 0;

  always #5 aclk = ~aclk;

  apb_transfer_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i), .cmd_burst_i(cmd_burst_i), .cmd_write_i(cmd_write_i),
    .true_psel_i(true_psel_i), .dec_error_i(dec_error_i), .nonexist_transfer_i(nonexist_transfer_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_resp_o(rsp_resp_o), .rsp_last_o(rsp_last_o)
  );

  // beat i address as a position inside the burst's aligned window
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int len, input logic [1:0] b, input int i);
    logic [31:0] bnd, base;
    bnd = 32'((len + 1) * 4);
    base = a - (a % bnd);
    if (b == BURST_FIXED) return a & ~32'd3;
    if (b == BURST_INCR) return (a + 32'(4 * i)) & ~32'd3;
    return (base + ((a - base + 32'(4 * i)) % bnd)) & ~32'd3;
  endfunction

  task automatic idle_inputs();
    cmd_valid_i = 0; cmd_addr_i = 0; cmd_len_i = 0; cmd_burst_i = 0; cmd_write_i = 0;
    true_psel_i = 0; dec_error_i = 0; nonexist_transfer_i = 0;
    wdata_valid_i = 0; wdata_i = 0; wstrb_i = 0;
    prdata_i = 0; pready_i = 0; pslverr_i = 0; rsp_ready_i = 0;
  endtask

  task automatic do_burst(input logic [31:0] a, input int len, input logic [1:0] b, input logic wr,
                          input logic [SLAVE_CNT-1:0] sel, input logic dec, input logic nonx,
                          input int wmin, input int wmax, input int serr, input logic rrand);
    logic err, sticky, done, exp_last;
    logic [1:0] code;
    logic [35:0] wq[$];
    logic [33:0] rq[$];
    logic [33:0] er;
    int apb_cnt, w_sent, r_got, wait_left, wait_set, acc, cyc;
    err = dec | nonx | (sel == '0) | (b == BURST_WRAP && !(len inside {1, 3, 7, 15}));
    code = dec ? RESP_DECERR : RESP_SLVERR;
    sticky = 0; done = 0; apb_cnt = 0; w_sent = 0; r_got = 0; wait_left = 0; wait_set = 0; acc = 0; cyc = 0;
    total++;
    if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready_o); end
    cmd_valid_i = 1; cmd_addr_i = a; cmd_len_i = 8'(len); cmd_burst_i = b; cmd_write_i = wr;
    true_psel_i = sel; dec_error_i = dec; nonexist_transfer_i = nonx;
    @(negedge aclk);
    cmd_valid_i = 0; cmd_addr_i = $urandom; true_psel_i = SLAVE_CNT'($urandom);
    dec_error_i = 1'($urandom); nonexist_transfer_i = 1'($urandom);
    while (!done && cyc < 1500) begin
      cyc++;
      if (psel_o != '0) begin
        total++;
        if (err || {psel_o, paddr_o, pwrite_o} !== {sel, exp_addr(a, len, b, apb_cnt), wr}) begin
          bad++;
          $display("FAIL apb_ctrl beat %0d got psel=%b paddr=%h pwrite=%b exp psel=%b paddr=%h pwrite=%b err=%b",
                   apb_cnt, psel_o, paddr_o, pwrite_o, sel, exp_addr(a, len, b, apb_cnt), wr, err);
        end
        if (wr) begin
          total++;
          if ({pwdata_o, pstrb_o} !== wq[apb_cnt]) begin
            bad++; $display("FAIL apb_wdata beat %0d got %h exp %h", apb_cnt, {pwdata_o, pstrb_o}, wq[apb_cnt]);
          end
        end
        if (!penable_o) begin wait_set = $urandom_range(wmax, wmin); wait_left = wait_set; acc = 0; end
        else acc++;
      end
      pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
      if (psel_o != '0 && penable_o) begin
        pready_i = wait_left == 0;
        if (wait_left > 0) wait_left--;
        pslverr_i = serr == 2 ? 1'($urandom) : 1'(serr);
        if (pready_i) begin
          total++;
          if (acc != wait_set + 1) begin bad++; $display("FAIL access_cycles got %0d exp %0d", acc, wait_set + 1); end
          apb_cnt++;
          if (wr) sticky |= pslverr_i;
          else rq.push_back({prdata_i, pslverr_i ? RESP_SLVERR : RESP_OKAY});
        end
      end
      wdata_valid_i = wr ? (w_sent <= len && $urandom_range(3, 0) != 0) : 1'($urandom);
      wdata_i = $urandom; wstrb_i = 4'($urandom);
      if (wdata_ready_o) begin
        total++;
        if (!wr || w_sent > len) begin bad++; $display("FAIL wready_spurious got 1 exp 0 sent=%0d", w_sent); end
        else if (wdata_valid_i) begin wq.push_back({wdata_i, wstrb_i}); w_sent++; end
      end
      rsp_ready_i = rrand ? 1'($urandom) : 1'b1;
      if (rsp_valid_o) begin
        if (wr) er = {32'h0, err ? code : sticky ? RESP_SLVERR : RESP_OKAY};
        else er = err ? {32'h0, code} : (rq.size() != 0 ? rq[0] : 34'bx);
        exp_last = wr || r_got == len;
        total++;
        if ({(wr ? 32'h0 : rsp_data_o), rsp_resp_o, rsp_last_o} !== {er, exp_last} ||
            (wr && (w_sent != len + 1 || (!err && apb_cnt != len + 1)))) begin
          bad++;
          $display("FAIL rsp beat %0d got data=%h resp=%b last=%b exp data=%h resp=%b last=%b wsent=%0d apb=%0d",
                   r_got, rsp_data_o, rsp_resp_o, rsp_last_o, er[33:2], er[1:0], exp_last, w_sent, apb_cnt);
        end
        if (rsp_ready_i) begin
          if (!wr && !err && rq.size() != 0) void'(rq.pop_front());
          r_got++;
          done = wr || r_got == len + 1;
        end
      end
      @(negedge aclk);
    end
    total++;
    if (!done) begin bad++; $display("FAIL burst_timeout got rsp=%0d exp %0d", r_got, wr ? 1 : len + 1); end
    total++;
    if (apb_cnt != (err ? 0 : len + 1)) begin bad++; $display("FAIL apb_count got %0d exp %0d", apb_cnt, err ? 0 : len + 1); end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 0;
    repeat (2) @(negedge aclk);
    total++;
    if ({cmd_ready_o, wdata_ready_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
         rsp_valid_o, rsp_data_o, rsp_resp_o, rsp_last_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got cmd_ready=%b psel=%b rsp_valid=%b exp all 0", cmd_ready_o, psel_o, rsp_valid_o);
    end
    aresetn = 1;
    @(negedge aclk);
    total++;
    if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready_o); end
  endtask

  task automatic test_read_incr();
    do_burst(32'h0, 3, BURST_INCR, 1'b0, SLAVE_CNT'(1), 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_write_wait();
    do_burst(32'h104, 0, BURST_INCR, 1'b1, SLAVE_CNT'(1) << (SLAVE_CNT - 1), 0, 0, 3, 3, 1, 1'b0);
  endtask

  task automatic test_wrap();
    do_burst(32'h0000_1018, 3, BURST_WRAP, 1'b0, SLAVE_CNT'(1), 0, 0, 0, 1, 2, 1'b0);
    do_burst(32'h0000_1018, 2, BURST_WRAP, 1'b0, SLAVE_CNT'(1), 0, 0, 0, 1, 2, 1'b0);
  endtask

  task automatic test_errors();
    do_burst(32'hF000_0000, 1, BURST_INCR, 1'b0, '0, 1, 0, 0, 0, 0, 1'b1);
    do_burst(32'h0000_0020, 2, BURST_INCR, 1'b1, SLAVE_CNT'(1), 0, 1, 0, 0, 0, 1'b1);
  endtask

  task automatic test_boundaries();
    do_burst(32'hFFFF_FFF8, 3, BURST_INCR, 1'b1, SLAVE_CNT'(1), 0, 0, 0, 2, 2, 1'b1);
    do_burst(32'h0000_0040, 3, BURST_FIXED, 1'b0, SLAVE_CNT'(1), 0, 0, 0, 2, 2, 1'b1);
    do_burst(32'h0000_0F00, 15, BURST_WRAP, 1'b1, SLAVE_CNT'(1), 0, 0, 0, 1, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    int wl[4] = '{1, 3, 7, 15};
    logic [1:0] b;
    logic [SLAVE_CNT-1:0] sel;
    int len;
    for (int n = 0; n < 40; n++) begin
      b = 2'($urandom_range(2, 0));
      len = (b == BURST_WRAP && $urandom_range(3, 0) != 0) ? wl[$urandom_range(3, 0)] : int'($urandom_range(7, 0));
      sel = '0;
      if ($urandom_range(7, 0) != 0) sel[$urandom_range(SLAVE_CNT - 1, 0)] = 1'b1;
      do_burst($urandom & ~32'd3, len, b, 1'($urandom), sel, $urandom_range(9, 0) == 0,
               $urandom_range(9, 0) == 0, 0, 3, 2, 1'($urandom));
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    cmd_valid_i = 1; cmd_addr_i = 32'h40; cmd_len_i = 3; cmd_burst_i = BURST_INCR; true_psel_i = SLAVE_CNT'(1);
    @(negedge aclk);
    cmd_valid_i = 0;
    for (int i = 0; i < 5 && !penable_o; i++) @(negedge aclk);
    total++;
    if (penable_o !== 1'b1) begin bad++; $display("FAIL areset_reach_access got %b exp 1", penable_o); end
    #2 aresetn = 0;
    #1;
    total++;
    if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o} !== '0) begin
      bad++; $display("FAIL areset_drop got psel=%b penable=%b rsp_valid=%b cmd_ready=%b exp 0", psel_o, penable_o, rsp_valid_o, cmd_ready_o);
    end
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    total++;
    if ({cmd_ready_o, psel_o, rsp_valid_o} !== {1'b1, {SLAVE_CNT{1'b0}}, 1'b0}) begin
      bad++; $display("FAIL areset_idle got cmd_ready=%b psel=%b rsp_valid=%b exp 1/0/0", cmd_ready_o, psel_o, rsp_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_read_incr();
    test_write_wait();
    test_wrap();
    test_errors();
    test_boundaries();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
